// File: rtl/alien_hit_detector_pkg.sv
// Shared constants for the alien formation: grid geometry, screen limits and
// collision FSM encoding. The draw logic uses the same values.
package alien_hit_detector_pkg;

    localparam int COLS    = 8;
    localparam int ROWS    = 4;
    localparam int CELL_W  = 16;
    localparam int CELL_H  = 12;
    localparam int ALIEN_W = 12;
    localparam int ALIEN_H = 8;

    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;

    localparam int N_ALIENS = ROWS * COLS;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int DIV_W    = X_W;
    localparam int COL_W    = 3;
    localparam int ROW_W    = 2;
    localparam int QUOT_W   = COL_W;
    localparam int LIM_W    = QUOT_W + 1;
    localparam int IDX_W    = $clog2(N_ALIENS);
    localparam int CNT_W    = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COL    = 3'd1,
        ROW    = 3'd2,
        CHECK  = 3'd3,
        RESULT = 3'd4
    } state_e;

    function automatic logic [IDX_W-1:0] cell_index(input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] row);
        return IDX_W'(int'(row) * COLS + int'(col));
    endfunction

endpackage

// File: rtl/alien_hit_detector_if.sv
// Bullet-in / result-out bundle between the shot controller and the hit detector.
interface alien_hit_detector_if;
    import alien_hit_detector_pkg::*;

    logic                 bullet_valid;
    logic [X_W-1:0]       bullet_x;
    logic [Y_W-1:0]       bullet_y;
    logic [X_W-1:0]       grid_x;
    logic [Y_W-1:0]       grid_y;
    logic                 grid_load;
    logic                 busy;
    logic                 result_valid;
    logic                 hit;
    logic [COL_W-1:0]     hit_col;
    logic [ROW_W-1:0]     hit_row;
    logic [N_ALIENS-1:0]  alive_mask;
    logic [CNT_W-1:0]     aliens_left;
    logic                 wave_clear;

    modport master (
        output bullet_valid, bullet_x, bullet_y, grid_x, grid_y, grid_load,
        input  busy, result_valid, hit, hit_col, hit_row, alive_mask, aliens_left, wave_clear
    );

    modport slave (
        input  bullet_valid, bullet_x, bullet_y, grid_x, grid_y, grid_load,
        output busy, result_valid, hit, hit_col, hit_row, alive_mask, aliens_left, wave_clear
    );

endinterface

// File: rtl/alien_hit_detector_grid_index_div.sv
// Iterative divide-by-subtraction: one pitch subtracted per step until the
// remainder drops below the pitch or the quotient would reach the limit.
module grid_index_div import alien_hit_detector_pkg::*; (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DIV_W-1:0]  value,
    input  logic [DIV_W-1:0]  pitch,
    input  logic [LIM_W-1:0]  limit,
    output logic [QUOT_W-1:0] quotient,
    output logic [DIV_W-1:0]  remainder,
    output logic              done,
    output logic              overflow
);

    logic [DIV_W-1:0]  rem_q, rem_d;
    logic [QUOT_W-1:0] quot_q, quot_d;

    assign done      = rem_q < pitch;
    assign overflow  = !done && ((LIM_W'(quot_q) + 1'b1) >= limit);
    assign quotient  = quot_q;
    assign remainder = rem_q;

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        if (load) begin
            rem_d  = value;
            quot_d = '0;
        end else if (step && !done && !overflow) begin
            rem_d  = rem_q - pitch;
            quot_d = quot_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quot_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

endmodule

// File: rtl/alien_hit_detector.sv
// Maps each bullet position onto the alien grid, kills a live alien under it
// and tracks how many aliens remain in the wave.
module alien_hit_detector import alien_hit_detector_pkg::*; (
    input logic               clk,
    input logic               reset,
    alien_hit_detector_if.slave bus
);

    state_e              state_q, state_d;
    logic [Y_W-1:0]      dy_q, dy_d;
    logic [DIV_W-1:0]    dxr_q, dxr_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                miss_q, miss_d;
    logic                kill_q, kill_d;
    logic [N_ALIENS-1:0] alive_q, alive_d;
    logic [CNT_W-1:0]    left_q, left_d;
    logic [COL_W-1:0]    hit_col_q, hit_col_d;
    logic [ROW_W-1:0]    hit_row_q, hit_row_d;

    logic                div_load, div_step, div_done, div_ovf;
    logic [DIV_W-1:0]    div_value, div_pitch, div_rem;
    logic [LIM_W-1:0]    div_limit;
    logic [QUOT_W-1:0]   div_quot;

    logic [DIV_W-1:0]    dx_full;
    logic [Y_W-1:0]      dy_full;
    logic                out_of_range;
    logic [IDX_W-1:0]    idx;

    // Compare before subtracting; a wrapped difference is never used when out of range.
    assign out_of_range = (bus.bullet_x < bus.grid_x) || (bus.bullet_y < bus.grid_y);
    assign dx_full      = bus.bullet_x - bus.grid_x;
    assign dy_full      = bus.bullet_y - bus.grid_y;
    assign idx          = cell_index(col_q, div_quot[ROW_W-1:0]);

    grid_index_div u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .value     (div_value),
        .pitch     (div_pitch),
        .limit     (div_limit),
        .quotient  (div_quot),
        .remainder (div_rem),
        .done      (div_done),
        .overflow  (div_ovf)
    );

    always_comb begin
        state_d   = state_q;
        dy_d      = dy_q;
        dxr_d     = dxr_q;
        col_d     = col_q;
        miss_d    = miss_q;
        kill_d    = kill_q;
        alive_d   = alive_q;
        left_d    = left_q;
        hit_col_d = hit_col_q;
        hit_row_d = hit_row_q;
        div_load  = 1'b0;
        div_step  = 1'b0;
        div_value = {{(DIV_W-Y_W){1'b0}}, dy_q};
        div_pitch = DIV_W'(CELL_W);
        div_limit = LIM_W'(COLS);

        case (state_q)
            IDLE: begin
                if (bus.bullet_valid) begin
                    miss_d    = out_of_range;
                    dy_d      = dy_full;
                    kill_d    = 1'b0;
                    div_load  = 1'b1;
                    div_value = dx_full;
                    state_d   = COL;
                end
            end
            // Out-of-range bullets pass through COL once, fixing the miss latency at 2.
            COL: begin
                if (miss_q || div_ovf) begin
                    state_d = RESULT;
                end else if (div_done) begin
                    col_d    = div_quot;
                    dxr_d    = div_rem;
                    div_load = 1'b1;
                    state_d  = ROW;
                end else begin
                    div_step = 1'b1;
                end
            end
            ROW: begin
                div_pitch = DIV_W'(CELL_H);
                div_limit = LIM_W'(ROWS);
                if (div_ovf)       state_d = RESULT;
                else if (div_done) state_d = CHECK;
                else               div_step = 1'b1;
            end
            // The divider still holds the row quotient and dy remainder here.
            CHECK: begin
                if (dxr_q < DIV_W'(ALIEN_W) && div_rem < DIV_W'(ALIEN_H) && alive_q[idx]) begin
                    alive_d[idx] = 1'b0;
                    if (left_q != '0) left_d = left_q - 1'b1;
                    hit_col_d = col_q;
                    hit_row_d = div_quot[ROW_W-1:0];
                    kill_d    = 1'b1;
                end
                state_d = RESULT;
            end
            RESULT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.grid_load) begin
            state_d = IDLE;
            alive_d = '1;
            left_d  = CNT_W'(N_ALIENS);
            kill_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dy_q      <= '0;
            dxr_q     <= '0;
            col_q     <= '0;
            miss_q    <= 1'b0;
            kill_q    <= 1'b0;
            alive_q   <= '1;
            left_q    <= CNT_W'(N_ALIENS);
            hit_col_q <= '0;
            hit_row_q <= '0;
        end else begin
            state_q   <= state_d;
            dy_q      <= dy_d;
            dxr_q     <= dxr_d;
            col_q     <= col_d;
            miss_q    <= miss_d;
            kill_q    <= kill_d;
            alive_q   <= alive_d;
            left_q    <= left_d;
            hit_col_q <= hit_col_d;
            hit_row_q <= hit_row_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.result_valid = (state_q == RESULT);
    assign bus.hit          = (state_q == RESULT) && kill_q;
    assign bus.wave_clear   = (state_q == RESULT) && kill_q && (left_q == '0);
    assign bus.hit_col      = hit_col_q;
    assign bus.hit_row      = hit_row_q;
    assign bus.alive_mask   = alive_q;
    assign bus.aliens_left  = left_q;

endmodule

// File: tb/tb_alien_hit_detector.sv
// Scoreboard bench for alien_hit_detector: a reference model predicts each
// lookup result and latency; a negedge monitor pops and compares.
module tb_alien_hit_detector;

    localparam int GX = 20;
    localparam int GY = 10;

    typedef struct {
        int          issue;
        int          lat;
        bit          hit;
        bit          wclr;
        logic [2:0]  col;
        logic [1:0]  row;
        logic [31:0] mask;
        logic [5:0]  left;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t        q[$];
    exp_t        e_mon;
    logic [31:0] m_mask = '1;
    int          m_left = 32;
    logic [2:0]  m_col = '0;
    logic [1:0]  m_row = '0;

    alien_hit_detector_if bus();

    alien_hit_detector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic shoot(input int x, input int y, input bit track);
        exp_t e;
        int dx, dy, c, r, idx;
        @(negedge clk);
        bus.bullet_x     = 8'(x);
        bus.bullet_y     = 7'(y);
        bus.bullet_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bullet_valid = 1'b0;
        if (track) begin
            e.issue = cyc;
            e.hit   = 1'b0;
            e.wclr  = 1'b0;
            if (x < GX || y < GY) begin
                e.lat = 2;
            end else begin
                dx = x - GX;
                dy = y - GY;
                c  = dx / 16;
                r  = dy / 12;
                if (c >= 8)      e.lat = 8 + 1;
                else if (r >= 4) e.lat = c + 4 + 2;
                else begin
                    e.lat = c + r + 4;
                    idx   = r * 8 + c;
                    if ((dx % 16) < 12 && (dy % 12) < 8 && m_mask[idx]) begin
                        m_mask[idx] = 1'b0;
                        m_left      = m_left - 1;
                        m_col       = 3'(c);
                        m_row       = 2'(r);
                        e.hit       = 1'b1;
                        e.wclr      = (m_left == 0);
                    end
                end
            end
            e.col  = m_col;
            e.row  = m_row;
            e.mask = m_mask;
            e.left = 6'(m_left);
            q.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_pending", q.size(), 0);
    endtask

    task automatic pulse_grid_load();
        @(negedge clk);
        bus.grid_load = 1'b1;
        @(negedge clk);
        bus.grid_load = 1'b0;
        m_mask = '1;
        m_left = 32;
    endtask

    always @(negedge clk) begin
        if (bus.result_valid) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e_mon = q.pop_front();
                check("latency", cyc - e_mon.issue + 1, e_mon.lat);
                check("hit", bus.hit, e_mon.hit);
                check("wave_clear", bus.wave_clear, e_mon.wclr);
                check("hit_col", bus.hit_col, e_mon.col);
                check("hit_row", bus.hit_row, e_mon.row);
                check("alive_mask", bus.alive_mask, e_mon.mask);
                check("aliens_left", bus.aliens_left, e_mon.left);
            end
        end else if (bus.hit || bus.wave_clear) begin
            check("pulse_outside_result", {bus.hit, bus.wave_clear}, 2'b00);
        end
    end

    initial begin
        bus.bullet_valid = 1'b0;
        bus.bullet_x     = '0;
        bus.bullet_y     = '0;
        bus.grid_x       = 8'(GX);
        bus.grid_y       = 7'(GY);
        bus.grid_load    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_hit", bus.hit, 0);
        check("rst_wave_clear", bus.wave_clear, 0);
        check("rst_hit_col", bus.hit_col, 0);
        check("rst_hit_row", bus.hit_row, 0);
        check("rst_alive_mask", bus.alive_mask, 32'hFFFF_FFFF);
        check("rst_aliens_left", bus.aliens_left, 32);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic hit, gaps, re-shoot, out-of-range, beyond grid
        shoot(55, 26, 1);  wait_done();
        check("t1_mask_bit10", bus.alive_mask[10], 0);
        shoot(32, 10, 1);  wait_done();
        shoot(20, 19, 1);  wait_done();
        shoot(55, 26, 1);  wait_done();
        shoot(10, 50, 1);  wait_done();
        shoot(150, 20, 1); wait_done();
        shoot(30, 115, 1); wait_done();

        // Dropped bullet while busy
        shoot(70, 50, 1);
        check("drop_busy_high", bus.busy, 1);
        shoot(20, 10, 0);
        wait_done();

        // grid_load during ROW aborts and restores
        shoot(39, 40, 0);
        repeat (3) @(negedge clk);
        bus.grid_load = 1'b1;
        @(negedge clk);
        bus.grid_load = 1'b0;
        m_mask = '1;
        m_left = 32;
        check("abort_load_busy", bus.busy, 0);
        check("abort_load_mask", bus.alive_mask, 32'hFFFF_FFFF);
        check("abort_load_left", bus.aliens_left, 32);
        wait_done();

        // Reset during ROW aborts and restores
        shoot(55, 26, 1); wait_done();
        shoot(39, 40, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        m_mask = '1;
        m_left = 32;
        m_col  = '0;
        m_row  = '0;
        check("abort_rst_busy", bus.busy, 0);
        check("abort_rst_mask", bus.alive_mask, 32'hFFFF_FFFF);
        check("abort_rst_left", bus.aliens_left, 32);
        check("abort_rst_hit_col", bus.hit_col, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_done();

        // Clear the whole wave
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                shoot(GX + 16 * c + 5, GY + 12 * r + 3, 1);
                wait_done();
            end
        check("clear_left", bus.aliens_left, 0);
        check("clear_mask", bus.alive_mask, 0);
        shoot(GX + 5, GY + 3, 1); wait_done();
        pulse_grid_load();
        check("reload_mask", bus.alive_mask, 32'hFFFF_FFFF);
        check("reload_left", bus.aliens_left, 32);

        // Random positions across the screen
        for (int i = 0; i < 16; i++) begin
            shoot(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), 1);
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
